// File: rtl/slot_mux32.sv
// 32-slot time-multiplexing serializer: a shadow bank takes writes, the active bank feeds the stream,
// and a commit copies shadow into active only on the edge where the slot counter wraps to 0.
module slot_mux32 #(
    parameter int unsigned width = 10,
    parameter logic [4:0]  stg   = 5'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic             commit_req,
    output logic             commit_ack,
    output logic             pending,
    output logic [4:0]       cnt,
    output logic [width-1:0] mixed,
    output logic             zero
);

    localparam logic [4:0] last_slot = 5'd31;
    // (cnt_next + 33 - stg) mod 32 folds to cnt_next + (1 - stg) in 5-bit arithmetic.
    localparam logic [4:0] rd_offset = 5'd1 - stg;

    logic [width-1:0] shadow [32];
    logic [width-1:0] active [32];

    logic             copy;
    logic [4:0]       cnt_next;
    logic [4:0]       rd_slot;
    logic [width-1:0] rd_value;

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        copy     = (pending | commit_req) & cen & (cnt == last_slot);
        cnt_next = cnt + 5'd1;
        rd_slot  = cnt_next + rd_offset;
        rd_value = active[rd_slot];
        // On the copy edge the stream already shows the incoming bank, including a same-edge write.
        if (copy) begin
            rd_value = shadow[rd_slot];
            if (wr_en && (wr_addr == rd_slot)) begin
                rd_value = wr_data;
            end
        end
    end

    // NOTE: both banks are cleared by reset on purpose, so they stay flops rather than RAM macros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (copy) begin
                for (int i = 0; i < 32; i++) begin
                    active[i] <= shadow[i];
                end
                if (wr_en) begin
                    active[wr_addr] <= wr_data;
                end
            end
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            mixed      <= '0;
            pending    <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            commit_ack <= copy;
            if (copy) begin
                pending <= 1'b0;
            end else if (commit_req) begin
                pending <= 1'b1;
            end
            if (cen) begin
                cnt   <= cnt_next;
                mixed <= rd_value;
            end
        end
    end

    assign zero = (cnt == 5'd0);

endmodule

// File: tb/tb_slot_mux32.sv
// Scoreboard bench for slot_mux32: two instances (stg=0 and stg=8) share stimulus, a reference
// model queues the expected outputs per edge, and a negedge monitor pops and compares.
module tb_slot_mux32;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, cen, wr_en, commit_req;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;

    logic         ack0, pend0, zero0, ack8, pend8, zero8;
    logic [4:0]   cnt0, cnt8;
    logic [W-1:0] mixed0, mixed8;

    slot_mux32 #(.width(W), .stg(5'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit_req(commit_req), .commit_ack(ack0), .pending(pend0),
        .cnt(cnt0), .mixed(mixed0), .zero(zero0)
    );

    slot_mux32 #(.width(W), .stg(5'd8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit_req(commit_req), .commit_ack(ack8), .pending(pend8),
        .cnt(cnt8), .mixed(mixed8), .zero(zero8)
    );

    typedef struct packed {
        logic [4:0]   cnt;
        logic [W-1:0] mixed0;
        logic [W-1:0] mixed8;
        logic         zero;
        logic         pending;
        logic         ack;
    } exp_t;

    exp_t exp_q[$];

    int checks    = 0;
    int failures  = 0;
    int ack_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [W-1:0] m_shadow [32];
    logic [W-1:0] m_active [32];
    logic [4:0]   m_cnt;
    logic [W-1:0] m_mixed0, m_mixed8;
    logic         m_pending, m_ack;

    task automatic model_step();
        logic       copy;
        logic [4:0] idx0, idx8;
        exp_t       e;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_cnt = '0; m_mixed0 = '0; m_mixed8 = '0; m_pending = 1'b0; m_ack = 1'b0;
        end else begin
            copy = (m_pending || commit_req) && cen && (m_cnt == 5'd31);
            if (copy) begin
                for (int i = 0; i < 32; i++) m_active[i] = m_shadow[i];
                if (wr_en) m_active[wr_addr] = wr_data;
            end
            if (wr_en) m_shadow[wr_addr] = wr_data;
            m_ack = copy;
            if (copy) m_pending = 1'b0;
            else if (commit_req) m_pending = 1'b1;
            if (cen) begin
                m_cnt    = m_cnt + 5'd1;
                idx0     = m_cnt + 5'd1;
                idx8     = m_cnt + 5'd1 - 5'd8;
                m_mixed0 = m_active[idx0];
                m_mixed8 = m_active[idx8];
            end
        end
        e.cnt     = m_cnt;
        e.mixed0  = m_mixed0;
        e.mixed8  = m_mixed8;
        e.zero    = (m_cnt == 5'd0);
        e.pending = m_pending;
        e.ack     = m_ack;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new output set every edge; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ack0 === 1'b1) ack_seen++;
            check("cnt0",    32'(cnt0),   32'(e.cnt));
            check("zero0",   32'(zero0),  32'(e.zero));
            check("pending0",32'(pend0),  32'(e.pending));
            check("ack0",    32'(ack0),   32'(e.ack));
            check("mixed0",  32'(mixed0), 32'(e.mixed0));
            check("cnt8",    32'(cnt8),   32'(e.cnt));
            check("zero8",   32'(zero8),  32'(e.zero));
            check("pending8",32'(pend8),  32'(e.pending));
            check("ack8",    32'(ack8),   32'(e.ack));
            check("mixed8",  32'(mixed8), 32'(e.mixed8));
        end
    end

    // Behavioural separator on the stg=8 stream: slot k lands in sep[k].
    logic [W-1:0] sep [32];
    always @(negedge clk) begin
        logic [4:0] sidx;
        sidx = cnt8 + 5'd1 - 5'd8;
        sep[sidx] <= mixed8;
    end

    task automatic cycle(input logic c, input logic we, input logic [4:0] wa,
                         input logic [W-1:0] wd, input logic cr, input logic rn);
        cen = c; wr_en = we; wr_addr = wa; wr_data = wd; commit_req = cr; rst_n = rn;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    endtask

    task automatic run_to(input logic [4:0] target);
        for (int i = 0; i < 64; i++) begin
            if (m_cnt == target) break;
            idle(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        // Reset held three cycles with cen high, then a full count frame.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check("reset_cnt", 32'(cnt0), 0);
        check("reset_zero", 32'(zero0), 1);
        idle(34);

        // Shadow writes with no commit: stream stays 0.
        for (int k = 0; k < 32; k++) cycle(1'b1, 1'b1, 5'(k), W'(k + 100), 1'b0, 1'b1);
        idle(64);
        check("no_commit_mixed", 32'(mixed0), 0);

        // Commit requested at cnt=5, takes effect on the wrap.
        run_to(5'd5);
        a = ack_seen;
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        check("pending_after_req", 32'(pend0), 1);
        idle(40);
        check("commit_one_ack", 32'(ack_seen - a), 1);
        run_to(5'd0);
        check("hand_cnt0_mixed", 32'(mixed0), 101);
        idle(1);
        check("hand_cnt1_mixed", 32'(mixed0), 102);

        // stg=8 round trip with slot k = 3k.
        for (int k = 0; k < 32; k++) cycle(1'b1, 1'b1, 5'(k), W'(3 * k), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        run_to(5'd31);
        idle(1);
        idle(34);
        for (int k = 0; k < 32; k++) check($sformatf("sep_slot%0d", k), 32'(sep[k]), 32'(3 * k));

        // Commit on the wrap edge itself with a bypassed write to slot 0.
        run_to(5'd31);
        cycle(1'b1, 1'b1, 5'd0, 10'h3FF, 1'b1, 1'b1);
        check("edge_ack", 32'(ack0), 1);
        check("edge_mixed_slot1", 32'(mixed0), 3);
        idle(40);
        check("edge_sep0", 32'(sep[0]), 32'h3FF);
        check("edge_sep1", 32'(sep[1]), 3);

        // Second request while pending is absorbed.
        run_to(5'd10);
        a = ack_seen;
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        idle(4);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        run_to(5'd0);
        idle(3);
        check("double_req_one_ack", 32'(ack_seen - a), 1);
        check("double_req_pending", 32'(pend0), 0);

        // cen toggling: hold on cen=0, copy only on a cen=1 wrap; write during cen=0.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 5'(k), W'(500 + k), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 5'd5, W'(777), 1'b0, 1'b1);
        for (int i = 0; i < 75; i++) begin
            cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
        end
        idle(34);
        check("cen_sep5", 32'(sep[5]), 777);

        // Reset while pending cancels the commit and clears both banks.
        idle(3);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        idle(3);
        check("pending_before_reset", 32'(pend0), 1);
        a = ack_seen;
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check("pending_after_reset", 32'(pend0), 0);
        idle(70);
        check("reset_no_ack", 32'(ack_seen - a), 0);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b1);
        idle(70);
        check("cleared_mixed", 32'(mixed0), 0);
        check("cleared_sep3", 32'(sep[3]), 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
